mem_rd_scheduler: RTL and testbench

- Read-side scheduler for the replay engine's shared external SRAM.
- Arbitrates round-robin among NUM_QUEUES replay queues; each queue owns an address region [addr_low, addr_high).
- Issues at most one read address per cycle to the memory controller, tagged with the queue ID, which steers returned data to that queue's output FIFO.
- Tracks a read pointer and replay-pass counter per queue; signals done when a queue completes its programmed number of passes.

---
 rtl/mem_rd_scheduler.sv | 175 +++++++++++++++++
 tb/tb_mem_rd_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_rd_scheduler                                           |
// | Description : Round-robin read scheduler for the replay engine's shared  |
// |               external SRAM. Issues one tagged read per cycle, walks     |
// |               each queue's address region and counts replay passes.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_rd_scheduler #(
   parameter int NUM_QUEUES       = 4,
   parameter int NUM_QUEUES_BITS  = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
   parameter int MEM_ADDR_WIDTH   = 19,
   parameter int REPLAY_CNT_WIDTH = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   sw_rst_i,
   input  logic                                   cal_done_i,
   input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]   q_addr_low_i,
   input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]   q_addr_high_i,
   input  logic [NUM_QUEUES-1:0]                  q_enable_i,
   input  logic [NUM_QUEUES*REPLAY_CNT_WIDTH-1:0] q_replay_cnt_i,
   input  logic [NUM_QUEUES-1:0]                  q_fifo_prog_full_i,
   input  logic                                   mem_rd_full_i,
   output logic                                   mem_r_n_o,
   output logic [MEM_ADDR_WIDTH-1:0]              mem_ad_rd_o,
   output logic [NUM_QUEUES_BITS-1:0]             mem_rd_qid_o,
   output logic [NUM_QUEUES-1:0]                  q_done_o,
   output logic [NUM_QUEUES*REPLAY_CNT_WIDTH-1:0] q_pass_cnt_o
);

   localparam logic [NUM_QUEUES_BITS:0]    c_NQ      = (NUM_QUEUES_BITS+1)'(NUM_QUEUES);
   localparam logic [NUM_QUEUES_BITS-1:0]  c_LAST_Q  = NUM_QUEUES_BITS'(NUM_QUEUES - 1);
   localparam logic [REPLAY_CNT_WIDTH-1:0] c_CNT_MAX = '1;

   // Either reset source clears everything and suppresses issue this cycle
   logic rst_any;
   assign rst_any = rst | sw_rst_i;

   // Unpacked views of the per-queue configuration buses
   logic [MEM_ADDR_WIDTH-1:0]   addr_low   [NUM_QUEUES];
   logic [MEM_ADDR_WIDTH-1:0]   addr_high  [NUM_QUEUES];
   logic [REPLAY_CNT_WIDTH-1:0] replay_cnt [NUM_QUEUES];

   // Per-queue state
   logic [MEM_ADDR_WIDTH-1:0]   rd_ptr_q   [NUM_QUEUES];
   logic [MEM_ADDR_WIDTH-1:0]   rd_ptr_d   [NUM_QUEUES];
   logic [REPLAY_CNT_WIDTH-1:0] pass_cnt_q [NUM_QUEUES];
   logic [REPLAY_CNT_WIDTH-1:0] pass_cnt_d [NUM_QUEUES];
   logic [NUM_QUEUES-1:0]       done_q;
   logic [NUM_QUEUES-1:0]       done_d;

   // Arbiter state and grant
   logic [NUM_QUEUES_BITS-1:0]  rr_q;
   logic [NUM_QUEUES_BITS-1:0]  rr_d;
   logic [NUM_QUEUES-1:0]       elig;
   logic                        gate;
   logic                        gnt_vld;
   logic [NUM_QUEUES_BITS-1:0]  gnt_idx;
   logic [NUM_QUEUES_BITS:0]    cand;

   // Registered memory command
   logic                        mem_r_n_q;
   logic [MEM_ADDR_WIDTH-1:0]   mem_ad_q;
   logic [NUM_QUEUES_BITS-1:0]  mem_qid_q;

   generate
      for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_queue
         assign addr_low[i]   = q_addr_low_i[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
         assign addr_high[i]  = q_addr_high_i[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
         assign replay_cnt[i] = q_replay_cnt_i[i*REPLAY_CNT_WIDTH +: REPLAY_CNT_WIDTH];
         // An empty or inverted region can never be read and never completes
         assign elig[i] = q_enable_i[i] & ~done_q[i] & ~q_fifo_prog_full_i[i]
                        & (addr_low[i] < addr_high[i]);
         assign q_pass_cnt_o[i*REPLAY_CNT_WIDTH +: REPLAY_CNT_WIDTH] = pass_cnt_q[i];
      end
   endgenerate

   // Backpressure is sampled combinationally: no skid buffer behind the issue stage
   assign gate = cal_done_i & ~mem_rd_full_i & ~rst_any;

   // Round-robin search starting at rr_q, first eligible queue in modulo order wins
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         cand = {1'b0, rr_q} + (NUM_QUEUES_BITS+1)'(k);
         if (cand >= c_NQ) begin
            cand = cand - c_NQ;
         end
         if (gate && !gnt_vld && elig[cand[NUM_QUEUES_BITS-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[NUM_QUEUES_BITS-1:0];
         end
      end
   end

   // Pointer moves past the granted queue; holds when nothing is granted
   always_comb begin
      rr_d = rr_q;
      if (gnt_vld) begin
         rr_d = (gnt_idx == c_LAST_Q) ? '0 : gnt_idx + NUM_QUEUES_BITS'(1);
      end
   end

   // Per-queue pointer / pass / done update; disable overrides a same-cycle grant
   always_comb begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
         rd_ptr_d[i]   = rd_ptr_q[i];
         pass_cnt_d[i] = pass_cnt_q[i];
         done_d[i]     = done_q[i];
         if (!q_enable_i[i]) begin
            rd_ptr_d[i]   = addr_low[i];
            pass_cnt_d[i] = '0;
            done_d[i]     = 1'b0;
         end else if (gnt_vld && (gnt_idx == NUM_QUEUES_BITS'(i))) begin
            if (rd_ptr_q[i] == addr_high[i] - MEM_ADDR_WIDTH'(1)) begin
               rd_ptr_d[i] = addr_low[i];
               // Saturate for infinite replay; a nonzero target sets done first
               if (pass_cnt_q[i] != c_CNT_MAX) begin
                  pass_cnt_d[i] = pass_cnt_q[i] + REPLAY_CNT_WIDTH'(1);
               end
               if ((replay_cnt[i] != '0) &&
                   (pass_cnt_q[i] + REPLAY_CNT_WIDTH'(1) == replay_cnt[i])) begin
                  done_d[i] = 1'b1;
               end
            end else begin
               rd_ptr_d[i] = rd_ptr_q[i] + MEM_ADDR_WIDTH'(1);
            end
         end
      end
   end

   // Queue and arbiter state registers
   always_ff @(posedge clk) begin
      if (rst_any) begin
         rr_q <= '0;
         for (int i = 0; i < NUM_QUEUES; i++) begin
            rd_ptr_q[i]   <= addr_low[i];
            pass_cnt_q[i] <= '0;
            done_q[i]     <= 1'b0;
         end
      end else begin
         rr_q <= rr_d;
         for (int i = 0; i < NUM_QUEUES; i++) begin
            rd_ptr_q[i]   <= rd_ptr_d[i];
            pass_cnt_q[i] <= pass_cnt_d[i];
            done_q[i]     <= done_d[i];
         end
      end
   end

   // Issue stage: the grant of cycle N appears on the memory port in cycle N+1
   always_ff @(posedge clk) begin
      if (rst_any) begin
         mem_r_n_q <= 1'b1;
         mem_ad_q  <= '0;
         mem_qid_q <= '0;
      end else begin
         mem_r_n_q <= ~gnt_vld;
         if (gnt_vld) begin
            mem_ad_q  <= rd_ptr_q[gnt_idx];
            mem_qid_q <= gnt_idx;
         end
      end
   end

   assign mem_r_n_o    = mem_r_n_q;
   assign mem_ad_rd_o  = mem_ad_q;
   assign mem_rd_qid_o = mem_qid_q;
   assign q_done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_rd_scheduler                                        |
// | Description : Self-checking bench for mem_rd_scheduler: directed         |
// |               scenarios plus randomized traffic against a queue model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_rd_scheduler;

   localparam int NQ = 4;
   localparam int AW = 19;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst, sw_rst, cal_done, mem_rd_full;
   logic [AW-1:0] lo [NQ];
   logic [AW-1:0] hi [NQ];
   logic [CW-1:0] rc [NQ];
   logic [NQ-1:0] en, pf;
   logic [NQ*AW-1:0] q_addr_low, q_addr_high;
   logic [NQ*CW-1:0] q_replay_cnt;

   logic            mem_r_n;
   logic [AW-1:0]   mem_ad_rd;
   logic [1:0]      mem_rd_qid;
   logic [NQ-1:0]   q_done;
   logic [NQ*CW-1:0] q_pass_cnt;

   // Reference model state (state after the most recent clock edge)
   logic [AW-1:0]    m_ptr [NQ];
   logic [CW-1:0]    m_cnt [NQ];
   logic [NQ-1:0]    m_done;
   int               m_rr;
   logic             exp_rn;
   logic [AW-1:0]    exp_ad;
   logic [1:0]       exp_qid;
   logic [NQ*CW-1:0] exp_pass;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   always_comb begin
      q_addr_low   = '0;
      q_addr_high  = '0;
      q_replay_cnt = '0;
      for (int i = 0; i < NQ; i++) begin
         q_addr_low[i*AW +: AW]   = lo[i];
         q_addr_high[i*AW +: AW]  = hi[i];
         q_replay_cnt[i*CW +: CW] = rc[i];
      end
   end

   mem_rd_scheduler #(
      .NUM_QUEUES(NQ), .NUM_QUEUES_BITS(2), .MEM_ADDR_WIDTH(AW), .REPLAY_CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .sw_rst_i(sw_rst), .cal_done_i(cal_done),
      .q_addr_low_i(q_addr_low), .q_addr_high_i(q_addr_high), .q_enable_i(en),
      .q_replay_cnt_i(q_replay_cnt), .q_fifo_prog_full_i(pf), .mem_rd_full_i(mem_rd_full),
      .mem_r_n_o(mem_r_n), .mem_ad_rd_o(mem_ad_rd), .mem_rd_qid_o(mem_rd_qid),
      .q_done_o(q_done), .q_pass_cnt_o(q_pass_cnt)
   );

   // Advance the model by one cycle from the current inputs, then clock the DUT
   task automatic tick();
      bit gv = 0;
      int g = 0;
      if (rst || sw_rst) begin
         for (int i = 0; i < NQ; i++) begin
            m_ptr[i] = lo[i]; m_cnt[i] = '0; m_done[i] = 1'b0;
         end
         m_rr = 0; exp_rn = 1'b1; exp_ad = '0; exp_qid = '0;
      end else begin
         if (cal_done && !mem_rd_full) begin
            for (int k = 0; k < NQ; k++) begin
               int q = (m_rr + k) % NQ;
               if (!gv && en[q] && !m_done[q] && !pf[q] && (lo[q] < hi[q])) begin
                  gv = 1; g = q;
               end
            end
         end
         exp_rn = !gv;
         if (gv) begin
            exp_ad = m_ptr[g];
            exp_qid = g[1:0];
            m_rr = (g + 1) % NQ;
            if (m_ptr[g] == hi[g] - 19'd1) begin
               m_ptr[g] = lo[g];
               if (m_cnt[g] != 16'hFFFF) m_cnt[g] = m_cnt[g] + 16'd1;
               if (rc[g] != 0 && m_cnt[g] == rc[g]) m_done[g] = 1'b1;
            end else begin
               m_ptr[g] = m_ptr[g] + 19'd1;
            end
         end
         for (int i = 0; i < NQ; i++) begin
            if (!en[i]) begin
               m_ptr[i] = lo[i]; m_cnt[i] = '0; m_done[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < NQ; i++) exp_pass[i*CW +: CW] = m_cnt[i];
      @(posedge clk);
      #1;
   endtask

   // Reset with every queue disabled and zero configuration
   task automatic reset_all();
      rst = 1'b1; sw_rst = 1'b0; cal_done = 1'b1; mem_rd_full = 1'b0;
      en = '0; pf = '0;
      for (int i = 0; i < NQ; i++) begin lo[i] = '0; hi[i] = '0; rc[i] = '0; end
   endtask

   task automatic setup_rr();
      reset_all();
      for (int i = 0; i < NQ; i++) begin
         lo[i] = 19'(i * 'h100); hi[i] = 19'(i * 'h100 + 'h100); rc[i] = '0;
      end
      tick();
      rst = 1'b0; en = 4'hF;
   endtask

   task automatic test_reset();
      reset_all();
      en = 4'hF;
      for (int i = 0; i < NQ; i++) begin lo[i] = 19'(i * 8); hi[i] = 19'(i * 8 + 4); end
      tick();
      n_cmp++; if (mem_r_n !== 1'b1) begin n_fail++; $display("FAIL reset_r_n: got %b want 1", mem_r_n); end
      n_cmp++; if (mem_ad_rd !== '0) begin n_fail++; $display("FAIL reset_ad: got %h want 0", mem_ad_rd); end
      n_cmp++; if (mem_rd_qid !== '0) begin n_fail++; $display("FAIL reset_qid: got %h want 0", mem_rd_qid); end
      n_cmp++; if (q_done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", q_done); end
      n_cmp++; if (q_pass_cnt !== '0) begin n_fail++; $display("FAIL reset_pass: got %h want 0", q_pass_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_single_queue();
      reset_all();
      lo[0] = 19'h10; hi[0] = 19'h14; rc[0] = 16'd2;
      tick();
      rst = 1'b0; en = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (mem_r_n !== 1'b0 || mem_ad_rd !== 19'(16 + k % 4) || mem_rd_qid !== 2'd0) begin
            n_fail++;
            $display("FAIL single_rd%0d: got r_n=%b ad=%h qid=%0d want r_n=0 ad=%h qid=0",
                     k, mem_r_n, mem_ad_rd, mem_rd_qid, 16 + k % 4);
         end
      end
      n_cmp++; if (q_done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", q_done); end
      n_cmp++; if (q_pass_cnt[15:0] !== 16'd2) begin n_fail++; $display("FAIL single_pass: got %0d want 2", q_pass_cnt[15:0]); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (mem_r_n !== 1'b1) begin n_fail++; $display("FAIL single_idle%0d: got r_n=%b want 1", k, mem_r_n); end
      end
   endtask

   task automatic test_round_robin();
      setup_rr();
      for (int k = 0; k < 16; k++) begin
         tick();
         n_cmp++;
         if (mem_r_n !== 1'b0 || mem_rd_qid !== 2'(k % 4) || mem_ad_rd !== 19'((k % 4) * 'h100 + k / 4)) begin
            n_fail++;
            $display("FAIL rr_%0d: got r_n=%b qid=%0d ad=%h want r_n=0 qid=%0d ad=%h",
                     k, mem_r_n, mem_rd_qid, mem_ad_rd, k % 4, (k % 4) * 'h100 + k / 4);
         end
      end
   endtask

   task automatic test_backpressure();
      int issued [NQ];
      int seq [6] = '{0, 2, 3, 0, 2, 3};
      for (int i = 0; i < NQ; i++) issued[i] = 0;
      setup_rr();
      for (int k = 0; k < 12; k++) begin
         if (k == 6) begin
            mem_rd_full = 1'b1;
            for (int s = 0; s < 5; s++) begin
               tick();
               n_cmp++; if (mem_r_n !== 1'b1) begin n_fail++; $display("FAIL bp_stall%0d: got r_n=%b want 1", s, mem_r_n); end
            end
            mem_rd_full = 1'b0;
         end
         tick();
         n_cmp++;
         if (mem_r_n !== 1'b0 || mem_rd_qid !== 2'(k % 4) || mem_ad_rd !== lo[k % 4] + 19'(issued[k % 4])) begin
            n_fail++;
            $display("FAIL bp_rd%0d: got r_n=%b qid=%0d ad=%h want r_n=0 qid=%0d ad=%h",
                     k, mem_r_n, mem_rd_qid, mem_ad_rd, k % 4, lo[k % 4] + 19'(issued[k % 4]));
         end
         issued[k % 4]++;
      end
      pf = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_cmp++;
         if (mem_r_n !== 1'b0 || mem_rd_qid !== 2'(seq[k]) || mem_ad_rd !== lo[seq[k]] + 19'(issued[seq[k]])) begin
            n_fail++;
            $display("FAIL pf_rd%0d: got r_n=%b qid=%0d ad=%h want r_n=0 qid=%0d ad=%h",
                     k, mem_r_n, mem_rd_qid, mem_ad_rd, seq[k], lo[seq[k]] + 19'(issued[seq[k]]));
         end
         issued[seq[k]]++;
      end
      pf = '0;
   endtask

   task automatic test_disable();
      reset_all();
      lo[2] = 19'h200; hi[2] = 19'h208; rc[2] = 16'd5;
      tick();
      rst = 1'b0; en = 4'b0100;
      for (int k = 0; k < 13; k++) tick();
      n_cmp++;
      if (q_pass_cnt[47:32] !== 16'd1 || mem_ad_rd !== 19'h204 || mem_rd_qid !== 2'd2) begin
         n_fail++;
         $display("FAIL dis_pre: got pass=%0d ad=%h qid=%0d want pass=1 ad=204 qid=2", q_pass_cnt[47:32], mem_ad_rd, mem_rd_qid);
      end
      en = 4'b0000;
      tick();
      n_cmp++;
      if (q_pass_cnt[47:32] !== 16'd0 || q_done !== 4'b0000 || mem_r_n !== 1'b1) begin
         n_fail++;
         $display("FAIL dis_clear: got pass=%0d done=%b r_n=%b want pass=0 done=0000 r_n=1", q_pass_cnt[47:32], q_done, mem_r_n);
      end
      en = 4'b0100;
      tick();
      n_cmp++;
      if (mem_r_n !== 1'b0 || mem_ad_rd !== 19'h200) begin
         n_fail++;
         $display("FAIL dis_restart: got r_n=%b ad=%h want r_n=0 ad=200", mem_r_n, mem_ad_rd);
      end
   endtask

   task automatic test_boundary();
      reset_all();
      lo[3] = 19'h20; hi[3] = 19'h20;
      lo[0] = 19'h30; hi[0] = 19'h31; rc[0] = 16'd3;
      tick();
      rst = 1'b0; en = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (mem_r_n !== 1'b0 || mem_ad_rd !== 19'h30 || mem_rd_qid !== 2'd0) begin
            n_fail++;
            $display("FAIL bnd_rd%0d: got r_n=%b ad=%h qid=%0d want r_n=0 ad=30 qid=0", k, mem_r_n, mem_ad_rd, mem_rd_qid);
         end
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if (mem_r_n !== 1'b1 || q_done !== 4'b0001 || q_pass_cnt[15:0] !== 16'd3) begin
            n_fail++;
            $display("FAIL bnd_idle%0d: got r_n=%b done=%b pass0=%0d want r_n=1 done=0001 pass0=3", k, mem_r_n, q_done, q_pass_cnt[15:0]);
         end
      end
   endtask

   task automatic test_sw_rst();
      setup_rr();
      for (int k = 0; k < 6; k++) tick();
      sw_rst = 1'b1;
      tick();
      n_cmp++;
      if (mem_r_n !== 1'b1 || q_pass_cnt !== '0 || q_done !== '0 || mem_ad_rd !== '0) begin
         n_fail++;
         $display("FAIL swrst: got r_n=%b pass=%h done=%b ad=%h want r_n=1 pass=0 done=0 ad=0", mem_r_n, q_pass_cnt, q_done, mem_ad_rd);
      end
      sw_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if (mem_r_n !== 1'b0 || mem_rd_qid !== 2'(k) || mem_ad_rd !== lo[k]) begin
            n_fail++;
            $display("FAIL swrst_rd%0d: got r_n=%b qid=%0d ad=%h want r_n=0 qid=%0d ad=%h", k, mem_r_n, mem_rd_qid, mem_ad_rd, k, lo[k]);
         end
      end
   endtask

   task automatic test_cal_done();
      setup_rr();
      cal_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n_cmp++; if (mem_r_n !== 1'b1) begin n_fail++; $display("FAIL cal_%0d: got r_n=%b want 1", k, mem_r_n); end
      end
      cal_done = 1'b1;
   endtask

   task automatic test_random();
      reset_all();
      tick();
      rst = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         mem_rd_full = ($urandom % 4) == 0;
         cal_done    = ($urandom % 16) != 0;
         sw_rst      = ($urandom % 250) == 0;
         for (int i = 0; i < NQ; i++) begin
            logic was = en[i];
            pf[i] = ($urandom % 5) == 0;
            if (($urandom % 30) == 0) en[i] = ~en[i];
            if (!was && !en[i]) begin
               lo[i] = 19'($urandom % 64);
               hi[i] = (($urandom % 8) == 0) ? 19'($urandom % 64) : lo[i] + 19'($urandom_range(1, 5));
               rc[i] = 16'($urandom % 4);
            end
         end
         tick();
         n_cmp++;
         if (mem_r_n !== exp_rn || mem_ad_rd !== exp_ad || mem_rd_qid !== exp_qid ||
             q_done !== m_done || q_pass_cnt !== exp_pass) begin
            n_fail++;
            $display("FAIL rand_%0d: got r_n=%b ad=%h qid=%0d done=%b pass=%h want r_n=%b ad=%h qid=%0d done=%b pass=%h",
                     t, mem_r_n, mem_ad_rd, mem_rd_qid, q_done, q_pass_cnt, exp_rn, exp_ad, exp_qid, m_done, exp_pass);
         end
      end
      sw_rst = 1'b0;
   endtask

   initial begin
      reset_all();
      test_reset();
      test_single_queue();
      test_round_robin();
      test_backpressure();
      test_disable();
      test_boundary();
      test_sw_rst();
      test_cal_done();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
